spi_sample_master: RTL and testbench
====================================

SPI_SAMPLE_MASTER -- requirements
Module: spi_sample_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 20: SCK half-period in Clk_100M cycles; legal range >= 1.
REQ-002 SHALL have parameter GAP_CYC, default 2000: inter-frame idle time in Clk_100M cycles with SCK low; legal range >= 1.
REQ-003 SHALL have port Clk_100M  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port ResetSwitch  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port TxData  in  16: sample to transmit, sent MSB first.
REQ-006 SHALL have port TxValid  in  1: TxData valid.
REQ-007 SHALL have port TxReady  out  1: block accepts TxData this cycle.
REQ-008 SHALL have port SCK  out  1: serial clock to the slave; idle low.
REQ-009 SHALL have port SDI  out  1: serial data to the slave.
REQ-010 SHALL have port SDO  in  1: serial data from the slave.
REQ-011 SHALL have port RxData  out  16: word captured from SDO during the last frame, MSB first.
REQ-012 SHALL have port RxValid  out  1: one-cycle pulse when RxData updates.
REQ-013 SHALL have port Busy  out  1: high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, SETUP, HIGH, LOW, GAP with a registered state, bit counter (0..15), divider counter (0..CLK_DIV-1) and gap counter (0..GAP_CYC-1).
REQ-015 SHALL drive TxReady = 1 only in IDLE; a transfer starts on a cycle with TxValid & TxReady.
REQ-016 On start SHALL load TxData into a 16-bit shift register, drive SDI = TxData[15] and enter SETUP; TxData changes after that cycle SHALL have no effect on the frame.
REQ-017 SETUP SHALL last CLK_DIV cycles with SCK = 0, then enter HIGH.
REQ-018 HIGH SHALL last CLK_DIV cycles with SCK = 1 and SDI held stable; on the cycle SCK rises, SDO SHALL be shifted into the LSB of the receive shift register.
REQ-019 After HIGH for bits 1..15, the block SHALL enter LOW: SCK = 0, SDI = next lower bit for CLK_DIV cycles, then return to HIGH.
REQ-020 After HIGH for the 16th bit, the block SHALL enter GAP: SCK = 0, SDI = 0, RxData = receive register, RxValid = 1 for exactly the first GAP cycle.
REQ-021 GAP SHALL last GAP_CYC cycles, then return to IDLE.
REQ-022 The first SCK rising edge SHALL occur CLK_DIV cycles after the accept cycle; each frame SHALL contain exactly 16 SCK pulses. Accept to GAP entry SHALL take 32*CLK_DIV cycles; accept to next TxReady SHALL take 32*CLK_DIV + GAP_CYC cycles.
REQ-023 SDI SHALL change only while SCK = 0, never on the same cycle that SCK rises or falls high-to-low relative to a sampled bit.
REQ-024 TxValid asserted while Busy SHALL be ignored; no queueing.
REQ-025 All outputs SHALL be registered and glitch-free.
REQ-026 With TxValid held high, back-to-back frames SHALL start on the IDLE cycle after GAP ends.

Reset
REQ-027 While ResetSwitch = 1, the block SHALL force state = IDLE, SCK = 0, SDI = 0, RxData = 16'h0000, RxValid = 0, Busy = 0, all counters 0, and TxReady = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no RxValid pulse.
REQ-029 TxReady SHALL rise on the first clock edge after ResetSwitch deasserts.

Verification
REQ-030 Defaults, TxData = 16'h01F4 pulsed with TxValid; SDO = 0 -> SDI at the 16 SCK rises reads 0000000111110100, 16 pulses each 20 cycles high, RxData = 16'h0000, RxValid pulses once at cycle 640 after accept.
REQ-031 SDO driven by a model slave returning 16'hA55A -> RxData = 16'hA55A with one RxValid pulse; Busy falls and TxReady rises 640 + 2000 cycles after accept.
REQ-032 CLK_DIV = 1, GAP_CYC = 1, TxValid held high with TxData = 16'hFFFF then 16'h0000 -> two frames of 32 cycles each, separated by 1 GAP cycle and 1 IDLE cycle; SDI is all ones then all zeros.
REQ-033 TxValid pulsed at bit 8 of a frame with different TxData -> ignored; the current frame completes unchanged, and no second frame follows.
REQ-034 ResetSwitch asserted during HIGH of bit 5 -> SCK and SDI are 0 immediately, no RxValid pulse, and RxData = 0; after release, a new 16'h01F4 frame transmits correctly.
REQ-035 Check continuously -> SDI never changes while SCK = 1; SCK = 0 whenever Busy = 0.

Source files
------------

// File: rtl/spi_sample_master.sv
// SPI master: 16-bit frames MSB first with SCK idle low; SDO is sampled on the cycle SCK rises.
// Each frame is followed by an SCK-low gap before the next word can be accepted.
module spi_sample_master #(
   parameter int CLK_DIV = 20,
   parameter int GAP_CYC = 2000
) (
   input  logic        Clk_100M,
   input  logic        ResetSwitch,
   input  logic [15:0] TxData,
   input  logic        TxValid,
   output logic        TxReady,
   output logic        SCK,
   output logic        SDI,
   input  logic        SDO,
   output logic [15:0] RxData,
   output logic        RxValid,
   output logic        Busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    bit_cnt, bit_nxt;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [15:0]   tx_sh, tx_sh_nxt;
   logic [15:0]   rx_sh, rx_sh_nxt;
   logic [15:0]   rx_data_nxt;
   logic          sck_nxt, sdi_nxt, rx_valid_nxt;
   logic          div_done;

   always_ff @(posedge Clk_100M or posedge ResetSwitch) begin
      if (ResetSwitch) begin
         state   <= IDLE;
         bit_cnt <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         RxData  <= '0;
         RxValid <= 1'b0;
         SCK     <= 1'b0;
         SDI     <= 1'b0;
         TxReady <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_nxt;
         div_cnt <= div_nxt;
         gap_cnt <= gap_nxt;
         tx_sh   <= tx_sh_nxt;
         rx_sh   <= rx_sh_nxt;
         RxData  <= rx_data_nxt;
         RxValid <= rx_valid_nxt;
         SCK     <= sck_nxt;
         SDI     <= sdi_nxt;
         TxReady <= (state_nxt == IDLE);
         Busy    <= (state_nxt != IDLE);
      end
   end

   assign div_done = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt    = state;
      bit_nxt      = bit_cnt;
      div_nxt      = div_cnt;
      gap_nxt      = gap_cnt;
      tx_sh_nxt    = tx_sh;
      rx_sh_nxt    = rx_sh;
      rx_data_nxt  = RxData;
      rx_valid_nxt = 1'b0;
      sck_nxt      = SCK;
      sdi_nxt      = SDI;
      case (state)
         IDLE: begin
            if (TxValid && TxReady) begin
               state_nxt = SETUP;
               tx_sh_nxt = TxData;
               sdi_nxt   = TxData[15];
               div_nxt   = '0;
               bit_nxt   = '0;
            end
         end
         SETUP, LOW: begin
            if (div_done) begin
               state_nxt = HIGH;
               div_nxt   = '0;
               sck_nxt   = 1'b1;
               rx_sh_nxt = {rx_sh[14:0], SDO};
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         HIGH: begin
            if (div_done) begin
               div_nxt = '0;
               sck_nxt = 1'b0;
               if (bit_cnt == 4'd15) begin
                  state_nxt    = GAP;
                  sdi_nxt      = 1'b0;
                  rx_data_nxt  = rx_sh;
                  rx_valid_nxt = 1'b1;
                  bit_nxt      = '0;
                  gap_nxt      = '0;
               end else begin
                  // next bit appears together with the falling SCK edge
                  state_nxt = LOW;
                  tx_sh_nxt = {tx_sh[14:0], 1'b0};
                  sdi_nxt   = tx_sh[14];
                  bit_nxt   = bit_cnt + 4'd1;
               end
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
               gap_nxt   = '0;
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_sample_master.sv
// Directed bench: default-parameter instance for frame timing/data/abort,
// and a CLK_DIV=1/GAP_CYC=1 instance for back-to-back streaming.
module tb_spi_sample_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] tx_data, rx_data;
   logic        tx_valid, tx_ready, sck, sdi, sdo, rx_valid, busy;
   logic [15:0] tx_data2, rx_data2;
   logic        tx_valid2, tx_ready2, sck2, sdi2, sdo2, rx_valid2, busy2;

   int total = 0;
   int bad = 0;

   localparam int D = 20;
   localparam int G = 2000;

   spi_sample_master #(.CLK_DIV(D), .GAP_CYC(G)) dut (
      .Clk_100M(clk), .ResetSwitch(rst), .TxData(tx_data), .TxValid(tx_valid),
      .TxReady(tx_ready), .SCK(sck), .SDI(sdi), .SDO(sdo), .RxData(rx_data),
      .RxValid(rx_valid), .Busy(busy));

   spi_sample_master #(.CLK_DIV(1), .GAP_CYC(1)) dut2 (
      .Clk_100M(clk), .ResetSwitch(rst), .TxData(tx_data2), .TxValid(tx_valid2),
      .TxReady(tx_ready2), .SCK(sck2), .SDI(sdi2), .SDO(sdo2), .RxData(rx_data2),
      .RxValid(rx_valid2), .Busy(busy2));

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({sck, sdi, rx_valid, busy, tx_ready} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got sck/sdi/rxv/busy/rdy=%b want 00000", {sck, sdi, rx_valid, busy, tx_ready});
      end
      total++;
      if (rx_data !== 16'h0000 || rx_data2 !== 16'h0000 || tx_ready2 !== 1'b0) begin
         bad++;
         $display("FAIL reset_rxdata: got %h/%h rdy2=%b want 0000/0000 0", rx_data, rx_data2, tx_ready2);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (tx_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_ready: got rdy=%b busy=%b want 1 0", tx_ready, busy);
      end
   endtask

   // Sends one frame on the default instance, model slave returns pat.
   task automatic check_frame(input logic [15:0] data, input logic [15:0] pat, input bit inject, input string name);
      int rises, first_rise, bad_high, hi_len, rxv_cnt, rxv_at, ready_at, viol, bit_idx, wait_c;
      logic [15:0] sdi_bits;
      logic prev_sck, prev_sdi;
      rises = 0; first_rise = -1; bad_high = 0; hi_len = 0; rxv_cnt = 0; rxv_at = -1;
      ready_at = -1; viol = 0; bit_idx = 0; sdi_bits = '0;
      wait_c = 0;
      while (tx_ready !== 1'b1 && wait_c < 5000) begin
         @(posedge clk);
         #1;
         wait_c++;
      end
      total++;
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_ready_timeout: got rdy=%b want 1", name, tx_ready);
         return;
      end
      tx_valid = 1'b1;
      tx_data = data;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data = 16'hDEAD;
      sdo = pat[15];
      prev_sck = sck;
      prev_sdi = sdi;
      for (int c = 1; c <= 32 * D + G + 2; c++) begin
         @(posedge clk);
         #1;
         if (sck && !prev_sck) begin
            if (rises == 0) first_rise = c;
            if (rises < 16) sdi_bits[15 - rises] = sdi;
            rises++;
            hi_len = 1;
         end else if (sck) begin
            hi_len++;
         end
         if (!sck && prev_sck) begin
            if (hi_len != D) bad_high++;
            bit_idx++;
            if (bit_idx < 16) sdo = pat[15 - bit_idx];
         end
         if (sck && sdi !== prev_sdi) viol++;
         if (!busy && sck) viol++;
         if (rx_valid) begin
            rxv_cnt++;
            rxv_at = c;
         end
         if (inject && c == 17 * D) begin
            tx_valid = 1'b1;
            tx_data = 16'hFFFF;
         end
         if (inject && c == 17 * D + 1) tx_valid = 1'b0;
         prev_sck = sck;
         prev_sdi = sdi;
         if (tx_ready) begin
            ready_at = c;
            break;
         end
      end
      total++;
      if (sdi_bits !== data) begin bad++; $display("FAIL %s_sdi_bits: got %b want %b", name, sdi_bits, data); end
      total++;
      if (rises != 16) begin bad++; $display("FAIL %s_pulses: got %0d want 16", name, rises); end
      total++;
      if (first_rise != D) begin bad++; $display("FAIL %s_first_rise: got %0d want %0d", name, first_rise, D); end
      total++;
      if (bad_high != 0) begin bad++; $display("FAIL %s_high_len: got %0d bad pulses want 0", name, bad_high); end
      total++;
      if (rxv_cnt != 1 || rxv_at != 32 * D) begin
         bad++;
         $display("FAIL %s_rxvalid: got %0d pulses last at %0d want 1 at %0d", name, rxv_cnt, rxv_at, 32 * D);
      end
      total++;
      if (rx_data !== pat) begin bad++; $display("FAIL %s_rxdata: got %h want %h", name, rx_data, pat); end
      total++;
      if (ready_at != 32 * D + G || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_ready_at: got %0d busy=%b want %0d busy=0", name, ready_at, busy, 32 * D + G);
      end
      total++;
      if (viol != 0) begin bad++; $display("FAIL %s_sck_rules: got %0d violations want 0", name, viol); end
      viol = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (busy || sck) viol++;
      end
      total++;
      if (viol != 0) begin bad++; $display("FAIL %s_no_second_frame: got %0d busy cycles want 0", name, viol); end
   endtask

   task automatic test_reset_abort();
      int wait_c;
      int rxv;
      wait_c = 0;
      while (tx_ready !== 1'b1 && wait_c < 5000) begin
         @(posedge clk);
         #1;
         wait_c++;
      end
      tx_valid = 1'b1;
      tx_data = 16'h01F4;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      sdo = 1'b1;
      for (int c = 1; c <= 185; c++) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (sck !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_in_high: got sck=%b busy=%b want 1 1", sck, busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({sck, sdi, rx_valid, busy, tx_ready} !== 5'b0 || rx_data !== 16'h0000) begin
         bad++;
         $display("FAIL abort_immediate: got sck/sdi/rxv/busy/rdy=%b rx=%h want 00000 0000",
                  {sck, sdi, rx_valid, busy, tx_ready}, rx_data);
      end
      rxv = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (rx_valid || sck) rxv++;
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      if (rx_valid) rxv++;
      total++;
      if (rxv != 0 || tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL abort_release: got %0d stray cycles rdy=%b want 0 1", rxv, tx_ready);
      end
      sdo = 1'b0;
      check_frame(16'h01F4, 16'h0000, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      int wait_c, rise_err, sdi_err, rxv_err, viol;
      logic prev_sck, prev_sdi;
      logic [15:0] rx_first;
      bit exp_rise;
      rise_err = 0; sdi_err = 0; rxv_err = 0; viol = 0; rx_first = 16'h5555;
      wait_c = 0;
      while (tx_ready2 !== 1'b1 && wait_c < 100) begin
         @(posedge clk);
         #1;
         wait_c++;
      end
      tx_valid2 = 1'b1;
      tx_data2 = 16'hFFFF;
      sdo2 = 1'b1;
      @(posedge clk);
      #1;
      tx_data2 = 16'h0000;
      prev_sck = sck2;
      prev_sdi = sdi2;
      for (int c = 1; c <= 70; c++) begin
         @(posedge clk);
         #1;
         exp_rise = (c % 2 == 1) && (c <= 31 || (c >= 35 && c <= 65));
         if ((sck2 && !prev_sck) != exp_rise) rise_err++;
         if (sck2 && !prev_sck && sdi2 !== (c <= 31 ? 1'b1 : 1'b0)) sdi_err++;
         if (rx_valid2 !== ((c == 32) || (c == 66))) rxv_err++;
         if (sck2 && sdi2 !== prev_sdi) viol++;
         if (!busy2 && sck2) viol++;
         if (c == 32) rx_first = rx_data2;
         if (c == 33) begin
            sdo2 = 1'b0;
            total++;
            if (tx_ready2 !== 1'b1 || busy2 !== 1'b0) begin
               bad++;
               $display("FAIL b2b_idle_cycle: got rdy=%b busy=%b want 1 0", tx_ready2, busy2);
            end
         end
         if (c == 34) begin
            tx_valid2 = 1'b0;
            total++;
            if (tx_ready2 !== 1'b0 || busy2 !== 1'b1) begin
               bad++;
               $display("FAIL b2b_restart: got rdy=%b busy=%b want 0 1", tx_ready2, busy2);
            end
         end
         prev_sck = sck2;
         prev_sdi = sdi2;
      end
      total++;
      if (rise_err != 0) begin bad++; $display("FAIL b2b_sck_rises: got %0d misplaced want 0", rise_err); end
      total++;
      if (sdi_err != 0) begin bad++; $display("FAIL b2b_sdi: got %0d wrong bits want 0", sdi_err); end
      total++;
      if (rxv_err != 0) begin bad++; $display("FAIL b2b_rxvalid: got %0d wrong cycles want 0", rxv_err); end
      total++;
      if (rx_first !== 16'hFFFF || rx_data2 !== 16'h0000) begin
         bad++;
         $display("FAIL b2b_rxdata: got %h then %h want ffff then 0000", rx_first, rx_data2);
      end
      total++;
      if (viol != 0 || tx_ready2 !== 1'b1) begin
         bad++;
         $display("FAIL b2b_end: got %0d violations rdy=%b want 0 1", viol, tx_ready2);
      end
   endtask

   initial begin
      rst = 1'b1;
      tx_data = 16'h0000; tx_valid = 1'b0; sdo = 1'b0;
      tx_data2 = 16'h0000; tx_valid2 = 1'b0; sdo2 = 1'b0;
      test_reset();
      check_frame(16'h01F4, 16'h0000, 1'b0, "basic");
      check_frame(16'h01F4, 16'hA55A, 1'b0, "slave_a55a");
      check_frame(16'h0F0F, 16'h1234, 1'b1, "ignore_busy");
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
